// File: rtl/uart_rx.sv
// 8-N-1 serial receiver (8-E-1 when UART_RX_PARITY_EN is defined); rx is synchronised, sampled mid-bit.
// Latency: rx_valid pulses at the stop-bit sample, ~9.5 bit times + SYNC_STAGES+1 clk after the start edge.
// Backpressure: none; host must take data within one frame time or it is overwritten by the next good frame.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       s_reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd5,
`endif
        WAIT_IDLE = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;
    logic                   half_end, bit_end;
    logic                   shift_en, stop_en;
`ifdef UART_RX_PARITY_EN
    logic                   par_en;
    logic                   par_flag;
`endif

    // Flops preset to 1 so a reset line reads idle rather than a start bit.
    always_ff @(posedge clk) begin
        if (s_reset) sync_q <= '1;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign half_end = (cnt == HALF_END);
    assign bit_end  = (cnt == BIT_END);

    always_ff @(posedge clk) begin
        if (s_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!rx_s) state_nxt = START;
            START:     if (half_end) state_nxt = rx_s ? IDLE : DATA;
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (bit_end) state_nxt = STOP;
`endif
            // Leaving STOP at mid-bit gives half a bit of margin to catch an immediate next start edge.
            STOP:      if (bit_end) state_nxt = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        shift_en = 1'b0;
        stop_en  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en   = 1'b0;
`endif
        case (state)
            DATA:    shift_en = bit_end;
            STOP:    stop_en  = bit_end;
`ifdef UART_RX_PARITY_EN
            PARITY:  par_en   = bit_end;
`endif
            default: ;
        endcase
    end

    // Counter restarts on every state change so each state measures time from its own entry.
    always_ff @(posedge clk) begin
        if (s_reset)                cnt <= '0;
        else if (state_nxt != state) cnt <= '0;
        else if (bit_end)            cnt <= '0;
        else                         cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (state != DATA) bit_idx <= 3'd0;
            if (shift_en) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (stop_en) begin
                if (rx_s) begin
                    data     <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (s_reset) begin
            par_flag   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            if (state == START)  par_flag   <= 1'b0;
            if (par_en)          par_flag   <= rx_s ^ (^shift);
            if (stop_en)         parity_err <= par_flag;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx; expected bytes and timings come from frame arithmetic.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SS   = 2;
    localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int BUSY_LEN = HALF + (FB - 1) * CPB;
    localparam int LAT      = BUSY_LEN + SS + 1;

    logic       clk = 1'b0;
    logic       s_reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       rx_valid, frame_err, parity_err, busy;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .s_reset   (s_reset),
        .rx        (rx),
        .data      (data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [7:0] vq[$];
    int vcyc[$];
    int ferr_n = 0, perr_n = 0, perr_v = 0, busy_n = 0, excl = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            vq.push_back(data);
            vcyc.push_back(cyc);
            if (parity_err) perr_v++;
        end
        if (frame_err) ferr_n++;
        if (parity_err) perr_n++;
        if (busy) busy_n++;
        if (rx_valid && frame_err) excl++;
        if (parity_err && !(rx_valid || frame_err)) excl++;
    end

    task automatic send_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb);
        send_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        send_bit(parb, CPB);
`else
        if (parb) ; // parity bit not on the wire in 8-N-1
`endif
        send_bit(stopb, CPB);
    endtask

    task automatic test_reset;
        s_reset = 1'b1;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", data); end
        checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        s_reset = 1'b0;
        repeat (CPB) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single;
        int v0, f0, b0, t0;
        logic [7:0] d;
        d = 8'hA5;
        v0 = vq.size(); f0 = ferr_n; b0 = busy_n; t0 = cyc;
        send_frame(d, 1'b1, ^d);
        send_bit(1'b1, 2 * CPB);
        checks++; if (vq.size() - v0 != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", vq.size() - v0); end
        else begin
            checks++; if (vq[v0] !== d) begin failures++; $display("FAIL single_data got=%h exp=%h", vq[v0], d); end
            checks++; if (vcyc[v0] - t0 < LAT - 1 || vcyc[v0] - t0 > LAT + 1) begin
                failures++; $display("FAIL single_latency got=%0d exp=%0d", vcyc[v0] - t0, LAT); end
        end
        checks++; if (data !== d) begin failures++; $display("FAIL single_hold got=%h exp=%h", data, d); end
        checks++; if (ferr_n != f0) begin failures++; $display("FAIL single_ferr got=%0d exp=0", ferr_n - f0); end
        checks++; if (busy_n - b0 < BUSY_LEN - 1 || busy_n - b0 > BUSY_LEN + 1) begin
            failures++; $display("FAIL single_busy got=%0d exp=%0d", busy_n - b0, BUSY_LEN); end
        last_good = d;
    endtask

    task automatic test_back_to_back;
        int v0;
        logic [7:0] a, b;
        a = 8'h00; b = 8'hFF;
        v0 = vq.size();
        send_frame(a, 1'b1, ^a);
        send_frame(b, 1'b1, ^b);
        send_bit(1'b1, 2 * CPB);
        checks++; if (vq.size() - v0 != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", vq.size() - v0); end
        else begin
            checks++; if (vq[v0] !== a) begin failures++; $display("FAIL b2b_first got=%h exp=%h", vq[v0], a); end
            checks++; if (vq[v0+1] !== b) begin failures++; $display("FAIL b2b_second got=%h exp=%h", vq[v0+1], b); end
            checks++; if (vcyc[v0+1] - vcyc[v0] < FB * CPB - 1 || vcyc[v0+1] - vcyc[v0] > FB * CPB + 1) begin
                failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", vcyc[v0+1] - vcyc[v0], FB * CPB); end
        end
        last_good = b;
    endtask

    task automatic test_glitch;
        int v0, f0, b0;
        v0 = vq.size(); f0 = ferr_n; b0 = busy_n;
        send_bit(1'b0, 5);
        send_bit(1'b1, 3 * CPB);
        checks++; if (vq.size() != v0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", vq.size() - v0); end
        checks++; if (ferr_n != f0) begin failures++; $display("FAIL glitch_ferr got=%0d exp=0", ferr_n - f0); end
        checks++; if (busy_n - b0 < HALF - 1 || busy_n - b0 > HALF + 1) begin
            failures++; $display("FAIL glitch_busy got=%0d exp=%0d", busy_n - b0, HALF); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    endtask

    task automatic test_frame_err;
        int v0, f0;
        logic [7:0] d;
        d = 8'h3C;
        v0 = vq.size(); f0 = ferr_n;
        send_frame(d, 1'b0, ^d);
        send_bit(1'b0, 40);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_busy_low got=%b exp=1", busy); end
        checks++; if (ferr_n - f0 != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", ferr_n - f0); end
        checks++; if (data !== last_good) begin failures++; $display("FAIL ferr_data got=%h exp=%h", data, last_good); end
        send_bit(1'b1, 3 * FB * CPB);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_release got=%b exp=0", busy); end
        checks++; if (ferr_n - f0 != 1) begin failures++; $display("FAIL ferr_after got=%0d exp=1", ferr_n - f0); end
        checks++; if (vq.size() != v0) begin failures++; $display("FAIL ferr_spurious got=%0d exp=0", vq.size() - v0); end
    endtask

    task automatic test_reset_midframe;
        int v0;
        logic [7:0] d, n;
        d = 8'h81; n = 8'h5A;
        send_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bit(d[i], CPB);
        send_bit(d[4], HALF);
        s_reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", data); end
        checks++; if ({rx_valid, frame_err, parity_err, busy} !== 4'b0000) begin
            failures++; $display("FAIL rst_mid_flags got=%b exp=0000", {rx_valid, frame_err, parity_err, busy}); end
        s_reset = 1'b0;
        repeat (CPB) @(negedge clk);
        v0 = vq.size();
        send_frame(n, 1'b1, ^n);
        send_bit(1'b1, 2 * CPB);
        checks++; if (vq.size() - v0 != 1) begin failures++; $display("FAIL rst_mid_count got=%0d exp=1", vq.size() - v0); end
        checks++; if (data !== n) begin failures++; $display("FAIL rst_mid_next got=%h exp=%h", data, n); end
        last_good = n;
    endtask

    task automatic test_random;
        int v0, f0, p0;
        logic [7:0] exp_q[$];
        logic [7:0] d;
        v0 = vq.size(); f0 = ferr_n; p0 = perr_n;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            send_frame(d, 1'b1, ^d);
            send_bit(1'b1, $urandom_range(0, 2 * CPB));
        end
        send_bit(1'b1, 2 * CPB);
        checks++; if (vq.size() - v0 != exp_q.size()) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d", vq.size() - v0, exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (vq[v0+i] !== exp_q[i]) begin
                    failures++; $display("FAIL rand_byte%0d got=%h exp=%h", i, vq[v0+i], exp_q[i]); end
            end
        end
        checks++; if (ferr_n != f0) begin failures++; $display("FAIL rand_ferr got=%0d exp=0", ferr_n - f0); end
        checks++; if (perr_n != p0) begin failures++; $display("FAIL rand_perr got=%0d exp=0", perr_n - p0); end
        last_good = exp_q[exp_q.size()-1];
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int v0, pv0;
        logic [7:0] d;
        d = 8'h07;
        v0 = vq.size(); pv0 = perr_v;
        send_frame(d, 1'b1, 1'b0);
        send_bit(1'b1, 2 * CPB);
        checks++; if (vq.size() - v0 != 1) begin failures++; $display("FAIL par_count got=%0d exp=1", vq.size() - v0); end
        checks++; if (perr_v - pv0 != 1) begin failures++; $display("FAIL par_err got=%0d exp=1", perr_v - pv0); end
        checks++; if (data !== d) begin failures++; $display("FAIL par_data got=%h exp=%h", data, d); end
        last_good = d;
    endtask
`endif

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_reset_midframe;
        test_random;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        checks++; if (excl != 0) begin failures++; $display("FAIL pulse_exclusive got=%0d exp=0", excl); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
